au_op_scheduler: RTL and testbench

//  Shares one 32-bit arithmetic unit (ADD/SUB/MUL/DIV, ALUop 00/01/10/11) between NUM_REQ requesters.

---
 rtl/au_sched_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/au_op_scheduler.sv | 243 ++++++++++++++++++++++++
 tb/tb_au_op_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/au_sched_pkg.sv
// Shared types and default latencies for the arithmetic-unit op scheduler.
package au_sched_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_ADDSUB_LAT = 1;
    localparam int DEF_MUL_LAT    = 33;
    localparam int DEF_DIV_LAT    = 33;

    function automatic int lat_max(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping to index 0.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    logic [NUM_REQ-1:0] hi_req_s;
    logic [ID_W-1:0]    win_hi_s;
    logic [ID_W-1:0]    win_lo_s;

    // Requests at/after the pointer take priority; otherwise the lowest index wins (wrap-around).
    always_comb begin
        hi_req_s = '0;
        win_hi_s = '0;
        win_lo_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_req_s[i] = req[i] && (ID_W'(i) >= ptr);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hi_req_s[i]) begin
                win_hi_s = ID_W'(i);
            end else begin
                win_hi_s = win_hi_s;
            end
            if (req[i]) begin
                win_lo_s = ID_W'(i);
            end else begin
                win_lo_s = win_lo_s;
            end
        end
        any    = |req;
        winner = (|hi_req_s) ? win_hi_s : win_lo_s;
        if (any) begin
            gnt = NUM_REQ'(1) << winner;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/au_op_scheduler.sv
// Shares one 32-bit ADD/SUB/MUL/DIV unit between NUM_REQ requesters, one op in flight, round-robin.
// Optional macro AU_SCHED_DIVZERO_EN: DIV by zero is answered locally with rsp_err=1, unit not used.
module au_op_scheduler
    import au_sched_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDSUB_LAT = DEF_ADDSUB_LAT,
    parameter int MUL_LAT    = DEF_MUL_LAT,
    parameter int DIV_LAT    = DEF_DIV_LAT,
    localparam int ID_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [2*NUM_REQ-1:0]    req_op,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [31:0]             au_a,
    output logic [31:0]             au_b,
    output logic [1:0]              au_aluop,
    output logic                    au_rst_n,
    input  logic [31:0]             au_s,
    input  logic [31:0]             au_hi,
    input  logic [31:0]             au_lo,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_s,
    output logic [31:0]             rsp_hi,
    output logic [31:0]             rsp_lo,
    output logic                    rsp_zero,
    output logic                    rsp_err
);

    localparam int MAX_LAT = lat_max(ADDSUB_LAT, MUL_LAT, DIV_LAT);
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        au_a_q, au_a_d;
    logic [31:0]        au_b_q, au_b_d;
    op_t                au_op_q, au_op_d;
    logic               au_rst_n_q, au_rst_n_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [31:0]        rsp_s_q, rsp_s_d;
    logic [31:0]        rsp_hi_q, rsp_hi_d;
    logic [31:0]        rsp_lo_q, rsp_lo_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] gnt_s;
    logic [ID_W-1:0]    winner_s;
    logic               any_s;
    logic [1:0]         sel_op_s;
    logic [31:0]        sel_a_s;
    logic [31:0]        sel_b_s;
    logic               dz_s;

    function automatic logic [CNT_W-1:0] lat_m1(input op_t op);
        logic [CNT_W-1:0] l;
        case (op)
            OP_ADD, OP_SUB: l = CNT_W'(ADDSUB_LAT - 1);
            OP_MUL:         l = CNT_W'(MUL_LAT - 1);
            OP_DIV:         l = CNT_W'(DIV_LAT - 1);
            default:        l = CNT_W'(MAX_LAT - 1);
        endcase
        return l;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt_s),
        .winner (winner_s),
        .any    (any_s)
    );

    // One-hot AND-OR mux of the winning requester's op and operands.
    always_comb begin
        sel_op_s = 2'b00;
        sel_a_s  = 32'h0000_0000;
        sel_b_s  = 32'h0000_0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_op_s = sel_op_s | (req_op[2*i +: 2] & {2{gnt_s[i]}});
            sel_a_s  = sel_a_s  | (req_a[32*i +: 32] & {32{gnt_s[i]}});
            sel_b_s  = sel_b_s  | (req_b[32*i +: 32] & {32{gnt_s[i]}});
        end
    end

`ifdef AU_SCHED_DIVZERO_EN
    assign dz_s = (sel_op_s == OP_DIV) && (sel_b_s == 32'h0000_0000);
`else
    assign dz_s = 1'b0;
`endif

    // Grants are offered only while idle and never while reset is held.
    always_comb begin
        if ((state_q == S_IDLE) && !rst) begin
            req_ready = gnt_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and next-output logic for the IDLE -> ISSUE -> WAIT -> RESP sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        au_a_d      = au_a_q;
        au_b_d      = au_b_q;
        au_op_d     = au_op_q;
        au_rst_n_d  = 1'b1;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_s_d     = rsp_s_q;
        rsp_hi_d    = rsp_hi_q;
        rsp_lo_d    = rsp_lo_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                rsp_valid_d = 1'b0;
                if (any_s) begin
                    au_a_d   = sel_a_s;
                    au_b_d   = sel_b_s;
                    au_op_d  = op_t'(sel_op_s);
                    rsp_id_d = winner_s;
                    if (winner_s == ID_W'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = winner_s + 1'b1;
                    end
                    if (dz_s) begin
                        // Remainder is the dividend, quotient saturates to all-ones.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_s_d     = 32'h0000_0000;
                        rsp_hi_d    = sel_a_s;
                        rsp_lo_d    = 32'hFFFF_FFFF;
                        rsp_zero_d  = 1'b0;
                    end else begin
                        state_d    = S_ISSUE;
                        au_rst_n_d = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d   = lat_m1(au_op_q);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    if ((au_op_q == OP_ADD) || (au_op_q == OP_SUB)) begin
                        rsp_s_d    = au_s;
                        rsp_hi_d   = 32'h0000_0000;
                        rsp_lo_d   = 32'h0000_0000;
                        rsp_zero_d = (au_s == 32'h0000_0000);
                    end else begin
                        rsp_s_d    = 32'h0000_0000;
                        rsp_hi_d   = au_hi;
                        rsp_lo_d   = au_lo;
                        rsp_zero_d = (au_hi == 32'h0000_0000) && (au_lo == 32'h0000_0000);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State, operand and response registers; reset drops any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            au_a_q      <= 32'h0000_0000;
            au_b_q      <= 32'h0000_0000;
            au_op_q     <= OP_ADD;
            au_rst_n_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_s_q     <= 32'h0000_0000;
            rsp_hi_q    <= 32'h0000_0000;
            rsp_lo_q    <= 32'h0000_0000;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            au_a_q      <= au_a_d;
            au_b_q      <= au_b_d;
            au_op_q     <= au_op_d;
            au_rst_n_q  <= au_rst_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_s_q     <= rsp_s_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign au_a      = au_a_q;
    assign au_b      = au_b_q;
    assign au_aluop  = au_op_q;
    assign au_rst_n  = au_rst_n_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_hi    = rsp_hi_q;
    assign rsp_lo    = rsp_lo_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_au_op_scheduler.sv
// Randomized scoreboard bench for au_op_scheduler with a latency-accurate arithmetic unit model.
module tb_au_op_scheduler;

    localparam int N   = 3;
    localparam int IDW = 2;
    localparam int AL  = 1;
    localparam int ML  = 4;
    localparam int DL  = 6;
`ifdef AU_SCHED_DIVZERO_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_rec_t;

    typedef struct {
        int          id;
        logic [31:0] s;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
        logic        err;
        logic        skip;
        int          due;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [2*N-1:0]    req_op = '0;
    logic [32*N-1:0]   req_a = '0;
    logic [32*N-1:0]   req_b = '0;
    logic [31:0]       au_a, au_b, au_s, au_hi, au_lo;
    logic [1:0]        au_aluop;
    logic              au_rst_n;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_s, rsp_hi, rsp_lo;
    logic              rsp_zero, rsp_err;

    int      total = 0;
    int      bad = 0;
    int      cyc = 0;
    op_rec_t pend [N][$];
    exp_t    sb [$];
    bit      busy = 1'b0;
    int      ptr = 0;
    int      gcyc = 0;
    op_rec_t gop;
    bit      gskip = 1'b0;
    bit      gen_en = 1'b0;
    bit      force_rdy = 1'b1;
    int      stall = 0;
    int      vpct = 10;

    au_op_scheduler #(
        .NUM_REQ(N), .ADDSUB_LAT(AL), .MUL_LAT(ML), .DIV_LAT(DL)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .au_a(au_a), .au_b(au_b), .au_aluop(au_aluop), .au_rst_n(au_rst_n),
        .au_s(au_s), .au_hi(au_hi), .au_lo(au_lo),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_s(rsp_s), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Arithmetic unit model: results become correct only LAT-1 cycles after its init pulse ends.
    int          ucnt = 0;
    logic [63:0] prod_s;
    int          lat_s;
    always @(posedge clk) begin
        if (!au_rst_n) ucnt <= 0;
        else if (ucnt < 100000) ucnt <= ucnt + 1;
    end
    always_comb begin
        prod_s = 64'(au_a) * 64'(au_b);
        lat_s  = (au_aluop == 2'b10) ? ML : (au_aluop == 2'b11) ? DL : AL;
        au_s   = 32'hBAD0_0000 ^ 32'(ucnt);
        au_hi  = 32'h5EED_0000 ^ 32'(ucnt);
        au_lo  = 32'h0DD0_0000 ^ 32'(ucnt);
        if (au_rst_n && (ucnt >= lat_s - 1)) begin
            case (au_aluop)
                2'b00: au_s = au_a + au_b;
                2'b01: au_s = au_a - au_b;
                2'b10: begin au_hi = prod_s[63:32]; au_lo = prod_s[31:0]; end
                default: begin
                    if (au_b == 32'd0) begin au_hi = au_a; au_lo = 32'hFFFF_FFFF; end
                    else begin au_hi = au_a % au_b; au_lo = au_a / au_b; end
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic exp_t model(input op_rec_t o, input int id, input int t);
        exp_t e;
        logic [63:0] p;
        e.id = id; e.s = 32'd0; e.hi = 32'd0; e.lo = 32'd0; e.err = 1'b0; e.skip = 1'b0;
        case (o.op)
            2'b00: e.s = o.a + o.b;
            2'b01: e.s = o.a - o.b;
            2'b10: begin p = 64'(o.a) * 64'(o.b); e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (o.b == 32'd0) begin e.hi = o.a; e.lo = 32'hFFFF_FFFF; end
                else begin e.hi = o.a % o.b; e.lo = o.a / o.b; end
            end
        endcase
        e.zero = (o.op < 2'b10) ? (e.s == 32'd0) : ((e.hi == 32'd0) && (e.lo == 32'd0));
        if (DZ && (o.op == 2'b11) && (o.b == 32'd0)) begin
            e.err = 1'b1; e.skip = 1'b1; e.zero = 1'b0; e.due = t + 1;
        end else begin
            e.due = t + 2 + ((o.op < 2'b10) ? AL : (o.op == 2'b10) ? ML : DL);
        end
        return e;
    endfunction

    function automatic op_rec_t rand_op();
        op_rec_t o;
        o.op = 2'($urandom_range(0, 3));
        o.a  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
        case ($urandom_range(0, 5))
            0: o.b = 32'd0;
            1: o.b = o.a;
            2: o.b = 32'($urandom_range(1, 20));
            default: o.b = $urandom();
        endcase
        return o;
    endfunction

    // One cycle: check grant/operands against the model at negedge, then drive new inputs.
    task automatic step();
        logic [N-1:0]    er;
        logic [2*N-1:0]  ops;
        logic [32*N-1:0] va, vb;
        int w;
        op_rec_t o;
        exp_t e;
        @(negedge clk);
        er = '0;
        w  = -1;
        if (!busy) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
            end
        end
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        if (busy) begin
            chk("au_a", 64'(au_a), 64'(gop.a));
            chk("au_b", 64'(au_b), 64'(gop.b));
            chk("au_aluop", 64'(au_aluop), 64'(gop.op));
            chk("au_rst_n", 64'(au_rst_n), ((cyc == gcyc + 1) && !gskip) ? 64'd0 : 64'd1);
        end
        if (w >= 0) begin
            o = pend[w].pop_front();
            e = model(o, w, cyc);
            sb.push_back(e);
            busy = 1'b1; gcyc = cyc; gop = o; gskip = e.skip; ptr = (w + 1) % N;
        end else if (busy && rsp_valid && rsp_ready) begin
            busy = 1'b0;
        end
        @(posedge clk);
        #1;
        ops = '0; va = '0; vb = '0;
        for (int j = 0; j < N; j++) begin
            if (gen_en && pend[j].size() < 3 && $urandom_range(0, 7) == 0) pend[j].push_back(rand_op());
            if (pend[j].size() > 0 && $urandom_range(0, 9) < vpct) begin
                er[j] = 1'b1;
                ops[2*j +: 2] = pend[j][0].op;
                va[32*j +: 32] = pend[j][0].a;
                vb[32*j +: 32] = pend[j][0].b;
            end else begin
                er[j] = 1'b0;
                ops[2*j +: 2] = 2'($urandom_range(0, 3));
                va[32*j +: 32] = $urandom();
                vb[32*j +: 32] = $urandom();
            end
        end
        req_valid = er; req_op = ops; req_a = va; req_b = vb;
        if (stall > 0) begin rsp_ready = 1'b0; stall--; end
        else if (force_rdy) rsp_ready = 1'b1;
        else rsp_ready = ($urandom_range(0, 3) != 0);
        if (!force_rdy && $urandom_range(0, 63) == 0) stall = $urandom_range(5, 15);
    endtask

    task automatic run_until_idle(input int lim);
        int i;
        bit pending;
        i = 0;
        do begin
            step();
            i++;
            pending = busy || (sb.size() > 0);
            for (int j = 0; j < N; j++) if (pend[j].size() > 0) pending = 1'b1;
        end while (pending && i < lim);
        chk("idle_timeout", 64'(pending), 64'd0);
    endtask

    task automatic chk_all_zero();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_au_a", 64'(au_a), 64'd0);
        chk("rst_au_b", 64'(au_b), 64'd0);
        chk("rst_au_aluop", 64'(au_aluop), 64'd0);
        chk("rst_au_rst_n", 64'(au_rst_n), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", {rsp_s, rsp_hi}, 64'd0);
        chk("rst_rsp_misc", {rsp_lo, 32'(rsp_id), 30'd0, rsp_zero, rsp_err}, 64'd0);
    endtask

    // Response monitor: compares every presented response with the scoreboard head.
    initial begin
        bit seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_spurious", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb[0];
                    if (!seen) chk("rsp_time", 64'(cyc), 64'(e.due));
                    seen = 1'b1;
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_s", 64'(rsp_s), 64'(e.s));
                    chk("rsp_hi", 64'(rsp_hi), 64'(e.hi));
                    chk("rsp_lo", 64'(rsp_lo), 64'(e.lo));
                    chk("rsp_zero", 64'(rsp_zero), 64'(e.zero));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (rsp_ready) begin
                        sb.delete(0);
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int g;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero();
        rst = 1'b0;
        force_rdy = 1'b1; vpct = 10;
        pend[0].push_back('{2'b00, 32'd5, 32'd7});
        run_until_idle(100);
        pend[1].push_back('{2'b01, 32'd9, 32'd9});
        run_until_idle(100);
        pend[0].push_back('{2'b10, 32'd3, 32'd4});
        pend[1].push_back('{2'b10, 32'd3, 32'd4});
        run_until_idle(100);
        pend[0].push_back('{2'b11, 32'd100, 32'd7});
        pend[1].push_back('{2'b00, 32'd1, 32'd2});
        stall = 20;
        run_until_idle(100);
        pend[2].push_back('{2'b11, 32'd10, 32'd0});
        run_until_idle(100);

        force_rdy = 1'b0; vpct = 8; gen_en = 1'b1;
        repeat (2500) step();
        gen_en = 1'b0; force_rdy = 1'b1; stall = 0;
        run_until_idle(600);

        // Reset in the middle of a MUL: op is dropped and the pointer returns to requester 0.
        pend[0].push_back('{2'b10, 32'hFFFF_FFFF, 32'd3});
        g = 0;
        while (!(busy && cyc >= gcyc + 3) && g < 100) begin
            step();
            g++;
        end
        chk("reached_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk_all_zero();
        sb.delete(); busy = 1'b0; ptr = 0;
        for (int j = 0; j < N; j++) pend[j].delete();
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pend[1].push_back('{2'b00, 32'd11, 32'd22});
        pend[2].push_back('{2'b01, 32'd5, 32'd9});
        pend[0].push_back('{2'b10, 32'd0, 32'd77});
        run_until_idle(200);
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
